// File: rtl/pdh_adc_frontend_pkg.sv
// Shared definitions for the PDH ADC front end: command opcodes, command/status
// bit positions, lane width and the decimation-exponent clamp.
package pdh_pkg;

  localparam int LANE_W = 16;
  localparam int DEC_W  = 4;
  localparam int RD_W   = 16;

  typedef enum logic [2:0] {
    OP_NOP         = 3'd0,
    OP_SET_DEC     = 3'd1,
    OP_SNAPSHOT    = 3'd2,
    OP_READ        = 3'd3,
    OP_CLEAR_FLAGS = 3'd4,
    OP_RSVD5       = 3'd5,
    OP_RSVD6       = 3'd6,
    OP_RSVD7       = 3'd7
  } opcode_e;

  localparam int CMD_TOG    = 31;
  localparam int CMD_OP_LSB = 28;
  localparam int CMD_CH_LSB = 24;

  localparam int ST_ACK     = 31;
  localparam int ST_SAT     = 30;
  localparam int ST_CERR    = 29;
  localparam int ST_DEC_LSB = 24;
  localparam int ST_SEQ_LSB = 16;

  function automatic logic [DEC_W-1:0] clamp_dec(input logic [3:0] arg,
                                                 input logic [DEC_W-1:0] max_v);
    logic [DEC_W-1:0] r;
    if (arg > max_v) begin
      r = max_v;
    end else begin
      r = arg;
    end
    return r;
  endfunction

endpackage

// File: rtl/pdh_adc_frontend_decimator.sv
// One channel of block-average decimation: accumulates sign-extended samples and
// emits the arithmetic-shifted block sum when the shared beat counter terminates.
module pdh_decimator
  import pdh_pkg::*;
#(
  parameter int ADC_BITS     = 14,
  parameter int DEC_MAX_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                beat,
  input  logic                blk_last,
  input  logic [DEC_W-1:0]    dec_log2,
  input  logic [ADC_BITS-1:0] sample,
  output logic [ADC_BITS-1:0] result
);

  localparam int ACC_W = ADC_BITS + DEC_MAX_LOG2;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sample_ext_s, sum_s;
  logic [ADC_BITS-1:0]     result_q, result_d;

  // Next accumulator / result; a clear drops the beat and leaves the result alone.
  always_comb begin
    sample_ext_s = {{DEC_MAX_LOG2{sample[ADC_BITS-1]}}, sample};
    sum_s        = acc_q + sample_ext_s;
    acc_d        = acc_q;
    result_d     = result_q;
    if (clr) begin
      acc_d = '0;
    end else if (beat) begin
      if (blk_last) begin
        result_d = ADC_BITS'(sum_s >>> dec_log2);
        acc_d    = '0;
      end else begin
        acc_d = sum_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/pdh_adc_frontend.sv
// PDH ADC front end: per-lane decimation, toggle-handshake command interface from
// the PS, snapshot/readback and sticky saturation / channel-error flags.
module pdh_adc_frontend
  import pdh_pkg::*;
#(
  parameter int NUM_CH             = 2,
  parameter int ADC_DATA_WIDTH     = LANE_W,
  parameter int ADC_BITS           = 14,
  parameter int DEC_MAX_LOG2       = 8,
  parameter int AXI_GPIO_IN_WIDTH  = 32,
  parameter int AXI_GPIO_OUT_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH*ADC_DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic                               S_AXIS_tvalid,
  input  logic [AXI_GPIO_IN_WIDTH-1:0]       axi_from_ps,
  output logic [AXI_GPIO_OUT_WIDTH-1:0]      axi_to_ps
);

  localparam logic [ADC_BITS-1:0] SAT_POS = {1'b0, {(ADC_BITS-1){1'b1}}};
  localparam logic [ADC_BITS-1:0] SAT_NEG = {1'b1, {(ADC_BITS-1){1'b0}}};
  localparam int                  PAD_W   = ADC_DATA_WIDTH - ADC_BITS;

  logic [AXI_GPIO_IN_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic                         last_tog_q, last_tog_d;
  logic                         ack_q, ack_d;
  logic                         sat_q, sat_d;
  logic                         cerr_q, cerr_d;
  logic [DEC_W-1:0]             dec_q, dec_d;
  logic [7:0]                   seq_q, seq_d;
  logic [RD_W-1:0]              rdata_q, rdata_d;
  logic [DEC_MAX_LOG2-1:0]      cnt_q, cnt_d;
  logic [NUM_CH-1:0][ADC_BITS-1:0] snap_q, snap_d;

  logic [NUM_CH-1:0][ADC_BITS-1:0] lane_s;
  logic [NUM_CH-1:0][ADC_BITS-1:0] result_s;
  logic                         cmd_tog_s;
  opcode_e                      cmd_op_s;
  logic [3:0]                   cmd_ch_s;
  logic [3:0]                   cmd_arg_s;
  logic                         exec_s;
  logic                         set_dec_s;
  logic                         clear_s;
  logic                         sat_evt_s;
  logic                         last_s;
  logic [DEC_MAX_LOG2:0]        term_s;
  logic [RD_W-1:0]              rd_sel_s;
  logic                         unused_bits_s;

  // Lane unpacking, saturation detect and command field extraction.
  always_comb begin
    sat_evt_s     = 1'b0;
    unused_bits_s = ^sync2_q[CMD_CH_LSB-1:4];
    for (int k = 0; k < NUM_CH; k++) begin
      lane_s[k] = S_AXIS_tdata[k*ADC_DATA_WIDTH +: ADC_BITS];
      unused_bits_s = unused_bits_s ^ (^S_AXIS_tdata[k*ADC_DATA_WIDTH+ADC_BITS +: PAD_W]);
      if (S_AXIS_tvalid && (lane_s[k] == SAT_POS || lane_s[k] == SAT_NEG)) begin
        sat_evt_s = 1'b1;
      end else begin
        sat_evt_s = sat_evt_s;
      end
    end
    cmd_tog_s = sync2_q[CMD_TOG];
    cmd_op_s  = opcode_e'(sync2_q[CMD_OP_LSB +: 3]);
    cmd_ch_s  = sync2_q[CMD_CH_LSB +: 4];
    cmd_arg_s = sync2_q[3:0];
    exec_s    = cmd_tog_s ^ last_tog_q;
    sync1_d   = axi_from_ps;
    sync2_d   = sync1_q;
    last_tog_d = cmd_tog_s;
  end

  // Shared beat counter; the terminal count is 2^dec_log2 - 1.
  always_comb begin
    term_s = ((DEC_MAX_LOG2+1)'(1) << dec_q) - (DEC_MAX_LOG2+1)'(1);
    last_s = ({1'b0, cnt_q} == term_s);
    cnt_d  = cnt_q;
    if (set_dec_s) begin
      cnt_d = '0;
    end else if (S_AXIS_tvalid) begin
      cnt_d = last_s ? '0 : cnt_q + DEC_MAX_LOG2'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Snapshot register selected by the READ channel field, sign-extended.
  always_comb begin
    rd_sel_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(cmd_ch_s) == k) begin
        rd_sel_s = {{(RD_W-ADC_BITS){snap_q[k][ADC_BITS-1]}}, snap_q[k]};
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
  end

  // Command execution; snapshots take the results as they stood before this edge.
  always_comb begin
    dec_d     = dec_q;
    seq_d     = seq_q;
    rdata_d   = rdata_q;
    snap_d    = snap_q;
    cerr_d    = cerr_q;
    clear_s   = 1'b0;
    set_dec_s = 1'b0;
    if (exec_s) begin
      case (cmd_op_s)
        OP_SET_DEC: begin
          dec_d     = clamp_dec(cmd_arg_s, DEC_W'(DEC_MAX_LOG2));
          set_dec_s = 1'b1;
        end
        OP_SNAPSHOT: begin
          snap_d = result_s;
          seq_d  = seq_q + 8'd1;
        end
        OP_READ: begin
          if (int'(cmd_ch_s) < NUM_CH) begin
            rdata_d = rd_sel_s;
          end else begin
            rdata_d = 16'h0000;
            cerr_d  = 1'b1;
          end
        end
        OP_CLEAR_FLAGS: begin
          clear_s = 1'b1;
          cerr_d  = 1'b0;
        end
        default: begin
          clear_s = 1'b0;
        end
      endcase
    end else begin
      clear_s = 1'b0;
    end
    sat_d = (clear_s ? 1'b0 : sat_q) | sat_evt_s;
    ack_d = ack_q ^ exec_s;
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      last_tog_q <= 1'b0;
      ack_q      <= 1'b0;
      sat_q      <= 1'b0;
      cerr_q     <= 1'b0;
      dec_q      <= '0;
      seq_q      <= 8'd0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      last_tog_q <= last_tog_d;
      ack_q      <= ack_d;
      sat_q      <= sat_d;
      cerr_q     <= cerr_d;
      dec_q      <= dec_d;
      seq_q      <= seq_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
    pdh_decimator #(
      .ADC_BITS     (ADC_BITS),
      .DEC_MAX_LOG2 (DEC_MAX_LOG2)
    ) u_dec (
      .clk      (clk),
      .rst      (rst),
      .clr      (set_dec_s),
      .beat     (S_AXIS_tvalid),
      .blk_last (last_s),
      .dec_log2 (dec_q),
      .sample   (lane_s[g]),
      .result   (result_s[g])
    );
  end

  // Status word assembled purely from registers.
  always_comb begin
    axi_to_ps                         = '0;
    axi_to_ps[ST_ACK]                 = ack_q;
    axi_to_ps[ST_SAT]                 = sat_q;
    axi_to_ps[ST_CERR]                = cerr_q;
    axi_to_ps[ST_DEC_LSB +: DEC_W]    = dec_q;
    axi_to_ps[ST_SEQ_LSB +: 8]        = seq_q;
    axi_to_ps[RD_W-1:0]               = rdata_q;
  end

endmodule

// File: tb/tb_pdh_adc_frontend.sv
// Self-checking bench for pdh_adc_frontend: command table, hand-written corner
// sequences and randomized beats scored against a block-average reference model.
module tb_pdh_adc_frontend;

  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic        tvalid;
  logic [31:0] from_ps;
  logic [31:0] to_ps;

  always #4 clk = ~clk;

  pdh_adc_frontend #(
    .NUM_CH(2), .ADC_DATA_WIDTH(16), .ADC_BITS(14), .DEC_MAX_LOG2(8),
    .AXI_GPIO_IN_WIDTH(32), .AXI_GPIO_OUT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid),
    .axi_from_ps(from_ps), .axi_to_ps(to_ps)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_sum[NCH];
  int m_res[NCH];
  int m_snap[NCH];
  int m_cnt, m_dec, m_seq, m_rdata;
  bit m_sat, m_cerr, m_ack, tog;

  typedef struct {
    int    op;
    int    ch;
    int    arg;
    int    exp_dec;
    int    exp_rd;
    bit    exp_cerr;
    string name;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {m_ack, m_sat, m_cerr, 1'b0, 4'(m_dec), 8'(m_seq), 16'(m_rdata)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_sum[k] = 0; m_res[k] = 0; m_snap[k] = 0;
    end
    m_cnt = 0; m_dec = 0; m_seq = 0; m_rdata = 0;
    m_sat = 0; m_cerr = 0; m_ack = 0; tog = 0;
  endtask

  // block mean with floor rounding, taken over every 2^dec valid beats
  task automatic model_beat(input int s0, input int s1, input bit acc);
    int s[NCH];
    s[0] = s0; s[1] = s1;
    for (int k = 0; k < NCH; k++)
      if (s[k] == 8191 || s[k] == -8192) m_sat = 1;
    if (acc) begin
      for (int k = 0; k < NCH; k++) m_sum[k] += s[k];
      m_cnt++;
      if (m_cnt == (1 << m_dec)) begin
        for (int k = 0; k < NCH; k++) begin
          m_res[k] = m_sum[k] >>> m_dec;
          m_sum[k] = 0;
        end
        m_cnt = 0;
      end
    end
  endtask

  task automatic model_cmd(input int op, input int ch, input int arg);
    case (op)
      1: begin
        m_dec = (arg > 8) ? 8 : arg;
        m_cnt = 0;
        for (int k = 0; k < NCH; k++) m_sum[k] = 0;
      end
      2: begin
        for (int k = 0; k < NCH; k++) m_snap[k] = m_res[k];
        m_seq = (m_seq + 1) % 256;
      end
      3: begin
        if (ch < NCH) m_rdata = m_snap[ch];
        else begin m_rdata = 0; m_cerr = 1; end
      end
      4: begin m_sat = 0; m_cerr = 0; end
      default: ;
    endcase
    m_ack = ~m_ack;
  endtask

  function automatic logic [31:0] cmd_word(input int op, input int ch, input int arg);
    return {tog, 3'(op), 4'(ch), 20'd0, 4'(arg)};
  endfunction

  task automatic drive_lanes(input int s0, input int s1);
    logic [1:0] p0, p1;
    p0 = 2'($urandom);
    p1 = 2'($urandom);
    tdata  = {p1, 14'(s1), p0, 14'(s0)};
    tvalid = 1'b1;
  endtask

  task automatic drive_beat(input int s0, input int s1);
    drive_lanes(s0, s1);
    model_beat(s0, s1, 1'b1);
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic send_cmd(input int op, input int ch, input int arg);
    int n;
    tog = ~tog;
    from_ps = cmd_word(op, ch, arg);
    model_cmd(op, ch, arg);
    n = 0;
    while (to_ps[31] !== m_ack && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("ack", {31'd0, to_ps[31]}, {31'd0, m_ack});
    check("status", to_ps, m_status());
    repeat (2) @(negedge clk);
    check("status_hold", to_ps, m_status());
  endtask

  // command and a valid beat land on the same clock edge
  task automatic cmd_with_beat(input int op, input int ch, input int arg,
                               input int s0, input int s1);
    tog = ~tog;
    from_ps = cmd_word(op, ch, arg);
    repeat (2) @(negedge clk);
    drive_lanes(s0, s1);
    model_cmd(op, ch, arg);
    model_beat(s0, s1, op != 1);
    @(negedge clk);
    tvalid = 1'b0;
    check("coincide_status", to_ps, m_status());
  endtask

  task automatic do_reset();
    rst = 1'b1; tvalid = 1'b0; from_ps = 32'd0;
    @(negedge clk);
    check("reset_status", to_ps, 32'h0000_0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic int rand_s();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 8191;
    if (r == 1) return -8192;
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tdata = 32'd0; tvalid = 1'b0; from_ps = 32'd0; rst = 1'b1;
    model_reset();
    tbl[0]  = '{1, 0, 12, 8, 0, 0, "setdec_clamp12"};
    tbl[1]  = '{1, 0, 3,  3, 0, 0, "setdec3"};
    tbl[2]  = '{1, 0, 15, 8, 0, 0, "setdec_clamp15"};
    tbl[3]  = '{1, 0, 8,  8, 0, 0, "setdec8"};
    tbl[4]  = '{3, 5, 0,  8, 0, 1, "read_ch5"};
    tbl[5]  = '{6, 0, 0,  8, 0, 1, "op6_nop"};
    tbl[6]  = '{4, 0, 0,  8, 0, 0, "clear_flags"};
    tbl[7]  = '{3, 2, 0,  8, 0, 1, "read_ch2"};
    tbl[8]  = '{0, 1, 7,  8, 0, 1, "nop"};
    tbl[9]  = '{4, 0, 0,  8, 0, 0, "clear_flags2"};
    tbl[10] = '{1, 0, 0,  0, 0, 0, "setdec0"};
    tbl[11] = '{3, 1, 0,  0, 0, 0, "read_ch1"};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      send_cmd(tbl[i].op, tbl[i].ch, tbl[i].arg);
      check({tbl[i].name, "_dec"},  {28'd0, to_ps[27:24]}, 32'(tbl[i].exp_dec));
      check({tbl[i].name, "_rd"},   {16'd0, to_ps[15:0]},  32'(tbl[i].exp_rd));
      check({tbl[i].name, "_cerr"}, {31'd0, to_ps[29]},    {31'd0, tbl[i].exp_cerr});
    end

    // full-scale sample with no decimation, then flag clear
    drive_beat(8191, 0);
    send_cmd(2, 0, 0);
    send_cmd(3, 0, 0);
    check("fullscale_rd",  {16'd0, to_ps[15:0]}, 32'h0000_1FFF);
    check("fullscale_sat", {31'd0, to_ps[30]},   32'd1);
    send_cmd(4, 0, 0);
    check("sat_cleared",   {31'd0, to_ps[30]},   32'd0);

    // decimate by 4 with gaps between valid beats
    send_cmd(1, 0, 2);
    drive_beat(100, 4);   repeat (2) @(negedge clk);
    drive_beat(-50, 8);   repeat (3) @(negedge clk);
    drive_beat(7, -4);    @(negedge clk);
    send_cmd(2, 0, 0);
    send_cmd(3, 1, 0);
    check("dec4_partial_ch1", {16'd0, to_ps[15:0]}, 32'h0000_0000);
    drive_beat(1, 0);     @(negedge clk);
    send_cmd(2, 0, 0);
    send_cmd(3, 1, 0);
    check("dec4_ch1", {16'd0, to_ps[15:0]}, 32'h0000_0002);
    send_cmd(3, 0, 0);
    check("dec4_ch0", {16'd0, to_ps[15:0]}, 32'h0000_000E);

    // snapshot coinciding with a result update keeps the old result
    send_cmd(1, 0, 0);
    drive_beat(-300, 55);
    cmd_with_beat(2, 0, 0, 1234, -77);
    send_cmd(3, 0, 0);
    check("snap_pre_ch0", {16'd0, to_ps[15:0]}, 32'h0000_FED4);
    send_cmd(3, 1, 0);
    check("snap_pre_ch1", {16'd0, to_ps[15:0]}, 32'h0000_0037);
    send_cmd(2, 0, 0);
    send_cmd(3, 0, 0);
    check("snap_post_ch0", {16'd0, to_ps[15:0]}, 32'h0000_04D2);

    // SET_DEC wins over a block completing on the same edge
    send_cmd(1, 0, 1);
    drive_beat(10, 20);
    cmd_with_beat(1, 0, 0, 30, 40);
    send_cmd(2, 0, 0);
    send_cmd(3, 0, 0);
    check("setdec_suppress_ch0", {16'd0, to_ps[15:0]}, 32'h0000_04D2);
    drive_beat(5, 6);
    send_cmd(2, 0, 0);
    send_cmd(3, 1, 0);
    check("after_setdec_ch1", {16'd0, to_ps[15:0]}, 32'h0000_0006);

    // saturated beat on the same edge as CLEAR_FLAGS leaves the flag set
    cmd_with_beat(4, 0, 0, -8192, 3);
    check("clear_vs_sat", {31'd0, to_ps[30]}, 32'd1);
    send_cmd(4, 0, 0);
    check("clear_after", {31'd0, to_ps[30]}, 32'd0);

    // randomized beats against the reference model
    for (int it = 0; it < 8; it++) begin
      send_cmd(1, 0, int'($urandom_range(0, 4)));
      for (int c = 0; c < 48; c++) begin
        if ($urandom_range(0, 1) == 1) drive_beat(rand_s(), rand_s());
        else @(negedge clk);
      end
      send_cmd(2, 0, 0);
      send_cmd(3, 0, 0);
      send_cmd(3, 1, 0);
      send_cmd(4, 0, 0);
    end

    // sequence wraps after 256 snapshots from reset
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_cmd(2, 0, 0);
      if (i == 254) check("seq_255", {24'd0, to_ps[23:16]}, 32'd255);
    end
    check("seq_wrap", {24'd0, to_ps[23:16]}, 32'd0);

    // reset in the middle of a block discards the partial sums
    send_cmd(1, 0, 3);
    drive_beat(1000, -1000);
    drive_beat(2000, 300);
    drive_beat(-7, 12);
    do_reset();
    drive_beat(-5, 9);
    send_cmd(2, 0, 0);
    send_cmd(3, 0, 0);
    check("post_reset_ch0", {16'd0, to_ps[15:0]}, 32'h0000_FFFB);
    send_cmd(3, 1, 0);
    check("post_reset_ch1", {16'd0, to_ps[15:0]}, 32'h0000_0009);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdh_adc_frontend.md
PDH_ADC_FRONTEND -- requirements
Module: pdh_adc_frontend

Interface
REQ-001 SHALL have parameter NUM_CH, 2, number of ADC lanes packed in S_AXIS_tdata.
REQ-002 SHALL have parameter ADC_DATA_WIDTH, 16, padded lane width.
REQ-003 SHALL have parameter ADC_BITS, 14, valid two's-complement bits per lane, at lane[ADC_BITS-1:0].
REQ-004 SHALL have parameter DEC_MAX_LOG2, 8, maximum decimation exponent.
REQ-005 SHALL have parameter AXI_GPIO_IN_WIDTH, 32, command word width; AXI_GPIO_OUT_WIDTH, 32, status word width.
REQ-006 SHALL have port clk  input  1  sole clock, 125 MHz; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port S_AXIS_tdata  input  NUM_CH*ADC_DATA_WIDTH  lane k at [16k+15:16k].
REQ-009 SHALL have port S_AXIS_tvalid  input  1  beat qualifier; no tready, every valid beat consumed.
REQ-010 SHALL have port axi_from_ps  input  32  command: [31] toggle strobe, [30:28] opcode, [27:24] channel, [3:0] argument.
REQ-011 SHALL have port axi_to_ps  output  32  status: [31] ack toggle, [30] sticky saturation, [29] sticky channel error, [27:24] current dec_log2, [23:16] snapshot sequence, [15:0] read data.

Function
REQ-012 SHALL sign-extend each lane's ADC_BITS field to ADC_BITS+DEC_MAX_LOG2 bits before accumulating.
REQ-013 SHALL, per channel, accumulate samples only on cycles with S_AXIS_tvalid=1; shared beat counter runs 0..2^dec_log2-1 and wraps.
REQ-014 SHALL, on the beat where counter = 2^dec_log2-1, write (acc+sample)>>>dec_log2 (arithmetic) into that channel's result register, clear acc, and reset counter; result visible 1 cycle after the beat.
REQ-015 SHALL with dec_log2=0 pass each valid sample to the result register with 1-cycle latency.
REQ-016 SHALL pass axi_from_ps through a 2-flop synchroniser; a command executes on the cycle the synchronised bit 31 differs from its last-seen value, exactly once per toggle.
REQ-017 SHALL toggle axi_to_ps[31] on the cycle after a command executes; PS issues next toggle only after observing ack.
REQ-018 SHALL decode opcode 0 NOP; 1 SET_DEC; 2 SNAPSHOT; 3 READ; 4 CLEAR_FLAGS; 5-7 treated as NOP but still acknowledged.
REQ-019 SHALL on SET_DEC load dec_log2=min(arg, DEC_MAX_LOG2) and discard all partial accumulations and counter.
REQ-020 SHALL on SNAPSHOT copy every channel's result register (pre-update value if updated the same cycle) into snapshot registers atomically and increment sequence mod 256 (255 wraps to 0).
REQ-021 SHALL on READ drive axi_to_ps[15:0] with snapshot[channel] sign-extended to 16 bits, held until the next READ; channel >= NUM_CH returns 0x0000 and sets bit 29.
REQ-022 SHALL set bit 30 when any lane's valid sample equals the most positive or most negative ADC_BITS value; held until CLEAR_FLAGS.
REQ-023 SHALL give CLEAR_FLAGS priority over a saturation event in the same cycle only for that cycle's prior state: flag ends set if a saturated beat coincides.
REQ-024 SHALL give SET_DEC priority over a coinciding decimation completion: no result update that cycle.

Reset
REQ-025 SHALL on rst clear accumulators, counter, results, snapshots, sequence, flags, dec_log2, read data, ack and synchroniser/last-seen bits to 0, so axi_to_ps = 0x00000000 one cycle after reset.
REQ-026 SHALL treat a first PS toggle of bit 31 from 0 to 1 after reset as a command; reset mid-accumulation discards partial sums.

Structure
REQ-027 SHALL place opcode constants, status bit positions and lane width in shared package pdh_pkg.
REQ-028 SHALL implement per-channel accumulation in sub-module pdh_decimator, instantiated NUM_CH times by generate; command decode and status in the top.

Verification
REQ-029 SHALL test dec_log2=0, lane0=0x1FFF: result 8191, bit 30 set; CLEAR_FLAGS then clears it.
REQ-030 SHALL test SET_DEC 2, lane1 samples 4,8,-4,0 valid with gaps: result 2 after fourth beat only; SNAPSHOT+READ ch1 returns 0x0002.
REQ-031 SHALL test SET_DEC 12 with DEC_MAX_LOG2=8: axi_to_ps[27:24]=8.
REQ-032 SHALL test READ channel 5 with NUM_CH=2: data 0x0000, bit 29 set, ack toggles.
REQ-033 SHALL test 256 SNAPSHOT commands: sequence returns to 0x00; rst asserted mid-accumulation yields axi_to_ps=0 next cycle.
